// File: rtl/multi_operand_acs.sv
// multi_operand_acs: sequential N-operand reducer (unsigned/signed sum, max, min).
// Operands and mode are captured on start. One channel is folded into the
// accumulator per clock, and result/idx are published with a one-cycle done pulse.
module multi_operand_acs #(
   parameter  int unsigned W     = 4,
   parameter  int unsigned N     = 4,
   parameter  int unsigned OUT_W = 8,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [N*W-1:0]     din,
   output logic               busy,
   output logic               done,
   output logic [OUT_W-1:0]   result,
   output logic [IDX_W-1:0]   idx
);

   // The result must hold a full N-way sum without overflow.
   if (OUT_W < W + $clog2(N)) begin : g_width_check
      $error("multi_operand_acs: OUT_W must be >= W + clog2(N)");
   end

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      MODE_USUM = 2'b00,
      MODE_MAX  = 2'b01,
      MODE_MIN  = 2'b10,
      MODE_SSUM = 2'b11
   } mode_t;

   state_t             state_q, state_d;
   mode_t              mode_q, mode_d;
   logic [N*W-1:0]     data_q, data_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   best_q, best_d;
   logic [OUT_W-1:0]   result_q, result_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;

   logic [W-1:0]       ch;
   logic [OUT_W-1:0]   acc_upd;
   logic [IDX_W-1:0]   best_upd;
   logic               last;

   // Select the captured channel addressed by the counter.
   always_comb begin
      ch = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (cnt_q == IDX_W'(k)) begin
            ch = data_q[k*W +: W];
         end
      end
   end

   // Fold the selected channel into the accumulator for the captured mode.
   // Ties in max/min keep the earlier channel, so the lowest index wins.
   always_comb begin
      acc_upd  = acc_q;
      best_upd = best_q;
      unique case (mode_q)
         MODE_USUM: acc_upd = acc_q + {{(OUT_W-W){1'b0}}, ch};
         MODE_SSUM: acc_upd = acc_q + {{(OUT_W-W){ch[W-1]}}, ch};
         MODE_MAX: begin
            if (ch > acc_q[W-1:0]) begin
               acc_upd  = {{(OUT_W-W){1'b0}}, ch};
               best_upd = cnt_q;
            end
         end
         MODE_MIN: begin
            if (ch < acc_q[W-1:0]) begin
               acc_upd  = {{(OUT_W-W){1'b0}}, ch};
               best_upd = cnt_q;
            end
         end
         default: ;
      endcase
   end

   assign last = (cnt_q == IDX_W'(N-1));

   // Next-state and datapath control for the IDLE/RUN handshake.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      best_d   = best_q;
      result_d = result_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               data_d  = din;
               mode_d  = mode_t'(mode);
               cnt_d   = '0;
               best_d  = '0;
               state_d = RUN;
               // Sums start from zero; max/min start from channel 0.
               if (mode_t'(mode) == MODE_MAX || mode_t'(mode) == MODE_MIN) begin
                  acc_d = {{(OUT_W-W){1'b0}}, din[W-1:0]};
               end else begin
                  acc_d = '0;
               end
            end
         end
         RUN: begin
            acc_d  = acc_upd;
            best_d = best_upd;
            cnt_d  = cnt_q + IDX_W'(1);
            if (last) begin
               state_d  = IDLE;
               cnt_d    = '0;
               result_d = acc_upd;
               idx_d    = (mode_q == MODE_MAX || mode_q == MODE_MIN) ? best_upd : '0;
               done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any reduction in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= MODE_USUM;
         data_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         best_q   <= '0;
         result_q <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         best_q   <= best_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign result = result_q;
   assign idx    = idx_q;

endmodule

// File: tb/tb_multi_operand_acs.sv
// tb_multi_operand_acs: directed table-driven bench for multi_operand_acs
// (W=4, N=4, OUT_W=8), plus hand-written back-to-back, start-while-busy and
// reset-mid-run sequences.
module tb_multi_operand_acs;

   localparam int unsigned W     = 4;
   localparam int unsigned N     = 4;
   localparam int unsigned OUT_W = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [N*W-1:0]   din;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] result;
   logic [1:0]       idx;

   int checks;
   int errors;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] din;
      logic [7:0]  exp_result;
      logic [1:0]  exp_idx;
   } vec_t;

   vec_t vecs[12];

   multi_operand_acs #(.W(W), .N(N), .OUT_W(OUT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .din    (din),
      .busy   (busy),
      .done   (done),
      .result (result),
      .idx    (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge: launches a reduction and checks the full busy/done timeline.
   task automatic run_vec(input int id, input logic [1:0] m, input logic [15:0] d,
                          input logic [7:0] er, input logic [1:0] ei);
      mode  = m;
      din   = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check($sformatf("v%0d busy c%0d", id, i), {31'b0, busy}, 32'd1);
         check($sformatf("v%0d nodone c%0d", id, i), {31'b0, done}, 32'd0);
         @(negedge clk);
      end
      check($sformatf("v%0d done", id), {31'b0, done}, 32'd1);
      check($sformatf("v%0d busy_low", id), {31'b0, busy}, 32'd0);
      check($sformatf("v%0d result", id), {24'b0, result}, {24'b0, er});
      check($sformatf("v%0d idx", id), {30'b0, idx}, {30'b0, ei});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      // channel k = din[4k+3:4k]; written most-significant channel first
      vecs[0]  = '{2'b00, 16'h7420, 8'h0D, 2'd0};
      vecs[1]  = '{2'b01, 16'h7420, 8'h07, 2'd3};
      vecs[2]  = '{2'b10, 16'h7420, 8'h00, 2'd0};
      vecs[3]  = '{2'b11, 16'h218F, 8'hFA, 2'd0};
      vecs[4]  = '{2'b00, 16'hFFFF, 8'h3C, 2'd0};
      vecs[5]  = '{2'b01, 16'h5555, 8'h05, 2'd0};
      vecs[6]  = '{2'b11, 16'h7420, 8'h0D, 2'd0};
      vecs[7]  = '{2'b01, 16'h218F, 8'h0F, 2'd0};
      vecs[8]  = '{2'b10, 16'h218F, 8'h01, 2'd2};
      vecs[9]  = '{2'b00, 16'h218F, 8'h1A, 2'd0};
      vecs[10] = '{2'b10, 16'h3563, 8'h03, 2'd0};
      vecs[11] = '{2'b01, 16'h3653, 8'h06, 2'd2};

      rst   = 1'b1;
      start = 1'b1;
      mode  = 2'b00;
      din   = 16'hFFFF;
      @(negedge clk);
      @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", {24'b0, result}, 32'd0);
      check("reset idx", {30'b0, idx}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 12; v++) begin
         run_vec(v, vecs[v].mode, vecs[v].din, vecs[v].exp_result, vecs[v].exp_idx);
         @(negedge clk);
         check($sformatf("v%0d done_pulse", v), {31'b0, done}, 32'd0);
         check($sformatf("v%0d result_hold", v), {24'b0, result}, {24'b0, vecs[v].exp_result});
      end

      // Back-to-back: second start issued in the done cycle of the first.
      run_vec(100, 2'b01, 16'h5555, 8'h05, 2'd0);
      run_vec(101, 2'b10, 16'h5555, 8'h05, 2'd0);
      @(negedge clk);
      check("b2b idle", {31'b0, busy}, 32'd0);

      // Start pulses and operand changes while busy are ignored.
      mode  = 2'b00;
      din   = 16'h7420;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("sb busy0", {31'b0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b01;
      din   = 16'hFFFF;
      @(negedge clk);
      din   = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("sb done", {31'b0, done}, 32'd1);
      check("sb result", {24'b0, result}, 32'h0D);
      check("sb idx", {30'b0, idx}, 32'd0);
      @(negedge clk);
      check("sb single_done", {31'b0, done}, 32'd0);
      check("sb no_restart", {31'b0, busy}, 32'd0);

      // Reset asserted in RUN cycle 2 aborts with no done.
      mode  = 2'b01;
      din   = 16'h3653;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rr busy", {31'b0, busy}, 32'd0);
      check("rr done", {31'b0, done}, 32'd0);
      check("rr result", {24'b0, result}, 32'd0);
      check("rr idx", {30'b0, idx}, 32'd0);
      for (int i = 0; i < N + 2; i++) begin
         @(negedge clk);
         check($sformatf("rr nodone c%0d", i), {31'b0, done}, 32'd0);
      end
      run_vec(200, 2'b01, 16'h3653, 8'h06, 2'd2);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
